muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two register read operands (rs, rt) for MULT/MULTU/DIV/DIVU, computes the result over 33 cycles with one-bit-per-cycle shift-add or restoring division, and holds the result in architectural HI/LO registers. MFHI/MFLO read HI/LO directly; MTHI/MTLO write them from rs.

---
 rtl/muldiv_unit.sv | 126 ++++++++++++
 tb/tb_muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: one bit per cycle shift-add multiply or
// restoring divide on operand magnitudes, signs applied in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] rt_in,
    input  logic             mthi_in,
    input  logic             mtlo_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       count_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic [WIDTH-1:0] work_hi_reg, work_lo_reg, opnd_reg;
    logic             is_div_reg, neg_res_reg, neg_rem_reg, done_reg;

    logic             is_signed, is_div, div_zero;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff, rem_next;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign is_signed = op_in[0];
    assign is_div    = op_in[1];
    assign div_zero  = (rt_in == '0);
    assign rs_abs    = (is_signed && rs_in[WIDTH-1]) ? -rs_in : rs_in;
    assign rt_abs    = (is_signed && rt_in[WIDTH-1]) ? -rt_in : rt_in;

    // Multiply: work_hi is the accumulator, work_lo the multiplier shifting out.
    assign mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opnd_reg} : '0);

    // Divide: work_hi is the remainder, work_lo the dividend becoming the quotient.
    assign div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
    assign rem_next  = div_ok ? div_diff : div_shift[WIDTH-1:0];

    assign prod      = {work_hi_reg, work_lo_reg};
    assign prod_neg  = -prod;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in) state_next = ITER;
            ITER:    if (count_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        is_div_reg  <= is_div;
                        // A zero divisor keeps the all-ones quotient unsigned, while
                        // negating the remainder magnitude restores the original rs.
                        neg_res_reg <= is_signed && (rs_in[WIDTH-1] ^ rt_in[WIDTH-1])
                                       && !(is_div && div_zero);
                        neg_rem_reg <= is_signed && is_div && rs_in[WIDTH-1];
                        work_hi_reg <= '0;
                        count_reg   <= '0;
                        work_lo_reg <= is_div ? rs_abs : rt_abs;
                        opnd_reg    <= is_div ? rt_abs : rs_abs;
                    end else begin
                        if (mthi_in) hi_reg <= rs_in;
                        if (mtlo_in) lo_reg <= rs_in;
                    end
                end
                ITER: begin
                    count_reg <= count_reg + 5'd1;
                    if (is_div_reg) begin
                        work_hi_reg <= rem_next;
                        work_lo_reg <= {work_lo_reg[WIDTH-2:0], div_ok};
                    end else begin
                        work_hi_reg <= mul_sum[WIDTH:1];
                        work_lo_reg <= {mul_sum[0], work_lo_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div_reg) begin
                        lo_reg <= neg_res_reg ? -work_lo_reg : work_lo_reg;
                        hi_reg <= neg_rem_reg ? -work_hi_reg : work_hi_reg;
                    end else begin
                        {hi_reg, lo_reg} <= neg_res_reg ? prod_neg : prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out = (state_reg != IDLE);
    assign done_out = done_reg;
    assign hi_out   = hi_reg;
    assign lo_out   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for the arithmetic plus
// hand-written sequences for MT writes, busy-time inputs and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] rs_in, rt_in;
    logic        mthi_in, mtlo_in;
    logic        busy_out, done_out;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_in(start_in), .op_in(op_in),
        .rs_in(rs_in), .rt_in(rt_in), .mthi_in(mthi_in), .mtlo_in(mtlo_in),
        .busy_out(busy_out), .done_out(done_out), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Launch one op; check hold of HI/LO after the start edge, latency, busy
    // length, result and that done lasts a single cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mt, input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                          input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int lat;
        int busy_cnt;
        logic seen;
        @(negedge clk);
        op_in = op; rs_in = a; rt_in = b; start_in = 1'b1;
        mthi_in = mt; mtlo_in = mt;
        @(posedge clk); #1;
        start_in = 1'b0; mthi_in = 1'b0; mtlo_in = 1'b0;
        op_in = ~op; rs_in = 32'hDEADBEEF; rt_in = 32'h0BADF00D;
        chk({tag, " hold_hi"}, {32'd0, hi_out}, {32'd0, pre_hi});
        chk({tag, " hold_lo"}, {32'd0, lo_out}, {32'd0, pre_lo});
        busy_cnt = busy_out ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        for (int n = 1; n <= 100 && !seen; n++) begin
            @(posedge clk); #1;
            if (done_out) begin
                seen = 1'b1;
                lat = n;
            end else if (busy_out) begin
                busy_cnt++;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'd33);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, " busy_at_done"}, {63'd0, busy_out}, 64'd0);
        chk({tag, " result"}, {hi_out, lo_out}, {ehi, elo});
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h lat=%0d (%s)", op, a, b, hi_out, lo_out, lat, tag);
        @(posedge clk); #1;
        chk({tag, " done_drop"}, {63'd0, done_out}, 64'd0);
    endtask

    task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] d,
                            input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        @(negedge clk);
        rs_in = d; mthi_in = hi_en; mtlo_in = lo_en;
        @(posedge clk); #1;
        mthi_in = 1'b0; mtlo_in = 1'b0;
        chk({tag, " hi"}, {32'd0, hi_out}, {32'd0, ehi});
        chk({tag, " lo"}, {32'd0, lo_out}, {32'd0, elo});
        $display("mt hi_en=%0d lo_en=%0d data=%h -> hi=%h lo=%h", hi_en, lo_en, d, hi_out, lo_out);
    endtask

    initial begin
        int dones;
        logic [31:0] pre_hi, pre_lo;

        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MULTU, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
        vecs[6]  = '{DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[8]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[10] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        reset = 1'b1; start_in = 1'b0; op_in = MULTU; rs_in = '0; rt_in = '0;
        mthi_in = 1'b0; mtlo_in = 1'b0;
        #1;
        chk("reset_state", {busy_out, done_out, hi_out, lo_out}, 66'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // MT writes in IDLE, separately and together
        mt_write(1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, "mthi");
        mt_write(1'b0, 1'b1, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, "mtlo");
        mt_write(1'b1, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, "mt_both");

        // Start together with MTHI/MTLO: the MT write is dropped
        run_op(MULTU, 32'd2, 32'd3, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'd0, 32'd6, "start_wins");

        pre_hi = 32'd0; pre_lo = 32'd6;
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, pre_hi, pre_lo,
                   vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
            pre_hi = vecs[i].hi; pre_lo = vecs[i].lo;
        end

        // Second start and MT writes while busy are ignored
        @(negedge clk);
        op_in = MULTU; rs_in = 32'd7; rt_in = 32'd6; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        dones = 0;
        repeat (4) @(negedge clk);
        op_in = DIVU; rs_in = 32'h55555555; rt_in = 32'd3;
        start_in = 1'b1; mthi_in = 1'b1; mtlo_in = 1'b1;
        @(posedge clk); #1;
        chk("busy_mt_hi", {32'd0, hi_out}, {32'd0, pre_hi});
        chk("busy_mt_lo", {32'd0, lo_out}, {32'd0, pre_lo});
        start_in = 1'b0; mthi_in = 1'b0; mtlo_in = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done_out) dones++;
        end
        chk("busy_restart_dones", 64'(dones), 64'd1);
        chk("busy_restart_result", {hi_out, lo_out}, {32'd0, 32'd42});
        $display("busy restart -> hi=%h lo=%h dones=%0d", hi_out, lo_out, dones);

        // Reset mid-operation aborts without a done pulse
        @(negedge clk);
        op_in = DIVU; rs_in = 32'd100; rt_in = 32'd7; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_state", {busy_out, done_out, hi_out, lo_out}, 66'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done_out || busy_out) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        $display("reset abort -> busy=%0d hi=%h lo=%h", busy_out, hi_out, lo_out);
        run_op(MULTU, 32'd7, 32'd6, 1'b0, 32'd0, 32'd0, 32'd0, 32'd42, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
